u22_rev: RTL and testbench
==========================

Name: u22_rev

Overview:
- Reverse-lookup engine for the u22 universal-gate wiring table: given an 18-bit target wiring word, returns the (func1, func2) pair whose wiring matches it.
- It searches sequentially by driving an external u22 wiring lookup instance through its func1/func2/pin inputs, one pin per cycle, and comparing each returned 3-bit code against the target.
- Used by configuration readback and self-check logic to recover the programmed function pair from a wiring image.

Parameters:
- STOP_FIRST, 0, 1 = finish on the first full match; 0 = sweep all 256 function pairs and count the matches.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  target wiring word presented
- req_ready  out  1  engine idle and able to accept a request
- req_wiring  in  18  target wiring; pin p occupies bits [3p+2:3p]
- tbl_func1  out  4  to lookup instance: func[7:4]
- tbl_func2  out  4  to lookup instance: func[3:0]
- tbl_pin  out  3  to lookup instance: pin index 0..5
- tbl_wiring  in  3  from lookup instance: combinational response, same cycle
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_found  out  1  at least one full match
- rsp_func1  out  4  lowest matching func[7:4]; 0 if none
- rsp_func2  out  4  lowest matching func[3:0]; 0 if none
- rsp_count  out  9  number of matching func values (0..256)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_found=0, rsp_func1/2=0, rsp_count=0, internal func=0, pin=0. tbl_* outputs are therefore 0.
- tbl_func1, tbl_func2 and tbl_pin are driven directly from the func and pin registers, with no combinational path from the inputs.
- States: IDLE, SCAN, DONE.
- IDLE: req_ready=1.
  - req_valid & req_ready: latch req_wiring into the target register, clear found/func result/count, set func=0 and pin=0, go to SCAN.
- SCAN: req_ready=0. Each cycle compare tbl_wiring with target[3*pin+:3].
  - Mismatch: abandon this func. If func==255 go to DONE; else func+1, pin=0.
  - Match, pin<5: pin+1.
  - Match, pin==5 (full match): count+1. If this is the first match, record func and set found=1.
    - STOP_FIRST=1: go to DONE.
    - Otherwise: if func==255 go to DONE; else func+1, pin=0.
- Each func costs 1..6 SCAN cycles.
  - Minimum scan length: 256 cycles (every func rejected at pin 0).
  - Maximum scan length: 1536 cycles.
- DONE: rsp_valid=1 and the rsp_* outputs are held stable while rsp_ready=0.
  - rsp_valid & rsp_ready: go to IDLE. req_ready rises the cycle after.
  - There is no bypass from DONE to SCAN.
- rsp_* outputs are registered and change only on entry to DONE or on a new request accept.
- Counter width: count saturates naturally at 256 and needs 9 bits; it must not wrap.
- Reset asserted mid-SCAN or in DONE: immediate return to reset values; the in-flight request is discarded.
- req_valid while not in IDLE: ignored, because req_ready=0. The requester must hold the request.
- Target codes 4..7 in any pin can never match, because lookup codes are 0..3. This is legal input and yields found=0.

Test Plan:
- Reset, then req_wiring=18'h00000 -> func 0x00 matches. rsp_found=1, rsp_func1=0, rsp_func2=0, rsp_count=1. The first 6 SCAN cycles drive tbl_func=0 with tbl_pin 0..5.
- req_wiring=18'b001_000_000_000_000_000 -> rsp_found=1, rsp_func1=4'hF, rsp_func2=4'hF, rsp_count=1. Check against a bench model built from the full u22 table.
- req_wiring=18'h3FFFF -> rsp_found=0, func outputs 0, rsp_count=0. rsp_valid asserts exactly 257 cycles after the accept cycle (256 SCAN cycles, one per func).
- STOP_FIRST=1 with the wiring of func 0x5A -> rsp_func1=4'h5, rsp_func2=4'hA. The scan ends at func 0x5A; tbl_func never exceeds 0x5A.
- Hold rsp_ready=0 for 20 cycles in DONE -> rsp_valid and all rsp_* outputs stay constant and req_ready=0. Then rsp_ready=1 -> IDLE next cycle, and a back-to-back request is accepted.
- Assert rst_n=0 mid-SCAN (func 0x40) -> all outputs take reset values asynchronously. After release, a new request for 18'h00000 returns func 0x00 and count 1.

Source files
------------

// File: rtl/u22_rev.sv
// u22_rev: reverse lookup of a u22 wiring word. Walks every (func1, func2) pair
// through an external wiring lookup, one pin per cycle, and reports the lowest match.
module u22_rev #(
   parameter bit STOP_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [17:0] req_wiring,
   output logic [3:0]  tbl_func1,
   output logic [3:0]  tbl_func2,
   output logic [2:0]  tbl_pin,
   input  logic [2:0]  tbl_wiring,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_found,
   output logic [3:0]  rsp_func1,
   output logic [3:0]  rsp_func2,
   output logic [8:0]  rsp_count
);

   localparam int unsigned WW    = 18;
   localparam int unsigned FW    = 8;
   localparam int unsigned PW    = 3;
   localparam int unsigned CW    = 9;
   localparam int unsigned CODEW = 3;
   localparam logic [PW-1:0] LAST_PIN  = PW'(5);
   localparam logic [FW-1:0] LAST_FUNC = FW'(255);

   // Encoding chosen so req_ready and rsp_valid are single state flops.
   typedef enum logic [1:0] {
      SCAN = 2'b00,
      IDLE = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t state, state_nxt;

   logic [WW-1:0]    target;
   logic [FW-1:0]    func;
   logic [PW-1:0]    pin;
   logic             acc_found;
   logic [FW-1:0]    acc_func;
   logic [CW-1:0]    acc_count;
   logic             res_found;
   logic [FW-1:0]    res_func;
   logic [CW-1:0]    res_count;

   logic [CODEW-1:0] tgt_code;
   logic             match;
   logic             full_hit;
   logic             last_func;
   logic             accept;
   logic             acc_found_nxt;
   logic [FW-1:0]    acc_func_nxt;
   logic [CW-1:0]    acc_count_nxt;

   // Target code for the pin currently being probed.
   always_comb begin
      tgt_code = '0;
      case (pin)
         3'd0:    tgt_code = target[2:0];
         3'd1:    tgt_code = target[5:3];
         3'd2:    tgt_code = target[8:6];
         3'd3:    tgt_code = target[11:9];
         3'd4:    tgt_code = target[14:12];
         3'd5:    tgt_code = target[17:15];
         default: tgt_code = '0;
      endcase
   end

   assign match     = (tbl_wiring == tgt_code);
   assign full_hit  = (state == SCAN) && match && (pin == LAST_PIN);
   assign last_func = (func == LAST_FUNC);
   assign accept    = (state == IDLE) && req_valid;

   assign acc_found_nxt = acc_found | full_hit;
   assign acc_func_nxt  = (full_hit && !acc_found) ? func : acc_func;
   assign acc_count_nxt = acc_count + CW'(full_hit);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_valid) state_nxt = SCAN;
         SCAN: begin
            if (!match) begin
               if (last_func) state_nxt = DONE;
            end else if (pin == LAST_PIN) begin
               if (STOP_FIRST || last_func) state_nxt = DONE;
            end
         end
         DONE: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded straight from the state flops.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE:    req_ready = 1'b1;
         DONE:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Scan datapath; result registers only move on accept or on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target    <= '0;
         func      <= '0;
         pin       <= '0;
         acc_found <= 1'b0;
         acc_func  <= '0;
         acc_count <= '0;
         res_found <= 1'b0;
         res_func  <= '0;
         res_count <= '0;
      end else if (accept) begin
         target    <= req_wiring;
         func      <= '0;
         pin       <= '0;
         acc_found <= 1'b0;
         acc_func  <= '0;
         acc_count <= '0;
         res_found <= 1'b0;
         res_func  <= '0;
         res_count <= '0;
      end else if (state == SCAN) begin
         acc_found <= acc_found_nxt;
         acc_func  <= acc_func_nxt;
         acc_count <= acc_count_nxt;
         if (state_nxt == DONE) begin
            res_found <= acc_found_nxt;
            res_func  <= acc_func_nxt;
            res_count <= acc_count_nxt;
         end else if (match && (pin != LAST_PIN)) begin
            pin <= pin + PW'(1);
         end else begin
            func <= func + FW'(1);
            pin  <= '0;
         end
      end
   end

   assign tbl_func1 = func[7:4];
   assign tbl_func2 = func[3:0];
   assign tbl_pin   = pin;
   assign rsp_found = res_found;
   assign rsp_func1 = res_func[7:4];
   assign rsp_func2 = res_func[3:0];
   assign rsp_count = res_count;

endmodule

// File: tb/tb_u22_rev.sv
// Bench for u22_rev: two instances (sweep-all and stop-first) each driving a
// behavioural wiring table, checked against hand-computed vectors.
module tb_u22_rev;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic [17:0] req_wiring [2];
   logic [3:0]  tbl_func1  [2];
   logic [3:0]  tbl_func2  [2];
   logic [2:0]  tbl_pin    [2];
   logic [2:0]  tbl_wiring [2];
   logic        rsp_valid  [2];
   logic        rsp_ready  [2];
   logic        rsp_found  [2];
   logic [3:0]  rsp_func1  [2];
   logic [3:0]  rsp_func2  [2];
   logic [8:0]  rsp_count  [2];

   int checks = 0;
   int errors = 0;

   // Bench wiring table: unique codes per func except funcs 0xC0..0xFE where
   // func[4] is ignored on pin 2 (pairs collide), and 0xFF which is pin5=1 only.
   function automatic logic [2:0] u22_code(input logic [7:0] f, input logic [2:0] p);
      logic [1:0] c;
      c = 2'd0;
      if (f == 8'hFF) return (p == 3'd5) ? 3'd1 : 3'd0;
      case (p)
         3'd0:    c = f[1:0];
         3'd1:    c = f[3:2];
         3'd2:    c = (f[7:6] == 2'b11) ? {f[5], 1'b0} : f[5:4];
         3'd3:    c = f[7:6];
         default: c = 2'd0;
      endcase
      return {1'b0, c};
   endfunction

   function automatic logic [17:0] model_wiring(input logic [7:0] f);
      logic [17:0] w;
      w = '0;
      for (int p = 0; p < 6; p++) w[3*p +: 3] = u22_code(f, 3'(p));
      return w;
   endfunction

   assign tbl_wiring[0] = u22_code({tbl_func1[0], tbl_func2[0]}, tbl_pin[0]);
   assign tbl_wiring[1] = u22_code({tbl_func1[1], tbl_func2[1]}, tbl_pin[1]);

   u22_rev #(.STOP_FIRST(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wiring(req_wiring[0]),
      .tbl_func1(tbl_func1[0]), .tbl_func2(tbl_func2[0]), .tbl_pin(tbl_pin[0]),
      .tbl_wiring(tbl_wiring[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_found(rsp_found[0]),
      .rsp_func1(rsp_func1[0]), .rsp_func2(rsp_func2[0]), .rsp_count(rsp_count[0])
   );

   u22_rev #(.STOP_FIRST(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wiring(req_wiring[1]),
      .tbl_func1(tbl_func1[1]), .tbl_func2(tbl_func2[1]), .tbl_pin(tbl_pin[1]),
      .tbl_wiring(tbl_wiring[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_found(rsp_found[1]),
      .rsp_func1(rsp_func1[1]), .rsp_func2(rsp_func2[1]), .rsp_count(rsp_count[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   // Scan trace captured during each request.
   logic [7:0] tr_func [6];
   logic [2:0] tr_pin  [6];
   int         nt;
   logic [7:0] maxf;

   // Issue a request at a negedge and wait for rsp_valid; edges counts the accept edge as 1.
   task automatic run_req(input int sel, input logic [17:0] w, output int edges);
      logic [7:0] f;
      req_valid[sel]  = 1'b1;
      req_wiring[sel] = w;
      nt   = 0;
      maxf = 8'h00;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      req_valid[sel] = 1'b0;
      while (!rsp_valid[sel] && edges < 2000) begin
         f = {tbl_func1[sel], tbl_func2[sel]};
         if (nt < 6) begin
            tr_func[nt] = f;
            tr_pin[nt]  = tbl_pin[sel];
            nt++;
         end
         if (f > maxf) maxf = f;
         @(negedge clk);
         edges++;
      end
      check("rsp_valid_timeout", 32'(rsp_valid[sel]), 32'd1);
   endtask

   task automatic ack(input int sel);
      rsp_ready[sel] = 1'b1;
      @(negedge clk);
      rsp_ready[sel] = 1'b0;
      check("idle_after_ack", 32'({req_ready[sel], rsp_valid[sel]}), 32'b10);
   endtask

   task automatic check_rsp(input string tag, input int sel, input logic found,
                            input logic [7:0] fn, input logic [8:0] cnt);
      check({tag, "_found"}, 32'(rsp_found[sel]), 32'(found));
      check({tag, "_func1"}, 32'(rsp_func1[sel]), 32'(fn[7:4]));
      check({tag, "_func2"}, 32'(rsp_func2[sel]), 32'(fn[3:0]));
      check({tag, "_count"}, 32'(rsp_count[sel]), 32'(cnt));
   endtask

   function automatic logic [30:0] snap(input int sel);
      return {req_ready[sel], rsp_valid[sel], rsp_found[sel], rsp_func1[sel], rsp_func2[sel],
              rsp_count[sel], tbl_func1[sel], tbl_func2[sel], tbl_pin[sel]};
   endfunction

   typedef struct {
      logic [17:0] wiring;
      int          sel;
      logic        found;
      logic [7:0]  func;
      logic [8:0]  count;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int          edges;
      logic [7:0]  rf;
      logic [17:0] rw;
      logic        m_found;
      logic [7:0]  m_func;
      logic [8:0]  m_count;
      logic [30:0] held;

      vecs[0] = '{18'h00000, 0, 1'b1, 8'h00, 9'd1};
      vecs[1] = '{18'h08000, 0, 1'b1, 8'hFF, 9'd1};
      vecs[2] = '{18'h3FFFF, 0, 1'b0, 8'h00, 9'd0};
      vecs[3] = '{18'h00252, 1, 1'b1, 8'h5A, 9'd1};
      vecs[4] = '{18'h00600, 0, 1'b1, 8'hC0, 9'd2};
      vecs[5] = '{18'h00600, 1, 1'b1, 8'hC0, 9'd1};
      vecs[6] = '{18'h04000, 0, 1'b0, 8'h00, 9'd0};
      vecs[7] = '{18'h0069A, 0, 1'b1, 8'hEE, 9'd2};
      vecs[8] = '{18'h00252, 0, 1'b1, 8'h5A, 9'd1};

      for (int s = 0; s < 2; s++) begin
         req_valid[s] = 1'b0; req_wiring[s] = '0; rsp_ready[s] = 1'b0;
      end
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("reset_async_dut0", 32'(snap(0)), 32'h4000_0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_dut0", 32'(snap(0)), 32'h4000_0000);
      check("reset_dut1", 32'(snap(1)), 32'h4000_0000);

      for (int i = 0; i < 9; i++) begin
         run_req(vecs[i].sel, vecs[i].wiring, edges);
         check_rsp($sformatf("vec%0d", i), vecs[i].sel, vecs[i].found, vecs[i].func, vecs[i].count);
         if (i == 0) begin
            for (int k = 0; k < 6; k++)
               check($sformatf("trace%0d", k), 32'({tr_func[k], tr_pin[k]}), 32'({8'h00, 3'(k)}));
         end
         if (vecs[i].wiring == 18'h3FFFF)
            check("nomatch_latency", 32'(edges), 32'd257);
         if (vecs[i].sel == 1 && vecs[i].found)
            check($sformatf("vec%0d_maxfunc", i), 32'(maxf), 32'(vecs[i].func));
         ack(vecs[i].sel);
      end

      // Model-derived targets from pseudo-random funcs.
      for (int r = 0; r < 2; r++) begin
         rf = 8'($urandom_range(0, 254));
         rw = model_wiring(rf);
         m_found = 1'b0; m_func = 8'h00; m_count = 9'd0;
         for (int f = 0; f < 256; f++) begin
            if (model_wiring(8'(f)) == rw) begin
               if (!m_found) m_func = 8'(f);
               m_found = 1'b1;
               m_count = m_count + 9'd1;
            end
         end
         run_req(0, rw, edges);
         check_rsp($sformatf("rand%0d", r), 0, m_found, m_func, m_count);
         ack(0);
      end

      // Result held while rsp_ready stays low, then back-to-back request.
      run_req(0, 18'h00600, edges);
      held = snap(0);
      check("hold_entry", 32'(held[30:29]), 32'b01);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check($sformatf("hold%0d", c), 32'(snap(0)), 32'(held));
      end
      rsp_ready[0]  = 1'b1;
      req_valid[0]  = 1'b1;
      req_wiring[0] = 18'h00000;
      @(negedge clk);
      rsp_ready[0] = 1'b0;
      check("b2b_idle", 32'({req_ready[0], rsp_valid[0]}), 32'b10);
      run_req(0, 18'h00000, edges);
      check_rsp("b2b", 0, 1'b1, 8'h00, 9'd1);
      ack(0);

      // Reset in the middle of a scan.
      req_valid[0]  = 1'b1;
      req_wiring[0] = 18'h3FFFF;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      edges = 0;
      while ({tbl_func1[0], tbl_func2[0]} != 8'h40 && edges < 400) begin
         @(negedge clk);
         edges++;
      end
      check("reach_func40", 32'({tbl_func1[0], tbl_func2[0]}), 32'h40);
      rst_n = 1'b0;
      #1;
      check("midscan_reset", 32'(snap(0)), 32'h4000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_idle", 32'(snap(0)), 32'h4000_0000);
      run_req(0, 18'h00000, edges);
      check_rsp("post_reset", 0, 1'b1, 8'h00, 9'd1);
      ack(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
